// File: rtl/zet_fetch_ctrl.sv
// Instruction byte collector: pops prefix/opcode/ModR/M/displacement/immediate
// bytes from the prefetch queue and holds exec_st until microcode ends the sequence.
module zet_fetch_ctrl #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       q_byte,
   input  logic             q_valid,
   output logic             q_pop,
   input  logic             block,
   input  logic             need_modrm,
   input  logic             need_off,
   input  logic             need_imm,
   input  logic             off_size,
   input  logic             imm_size,
   input  logic             end_seq,
   output logic [7:0]       opcode,
   output logic [7:0]       modrm,
   output logic [15:0]      off,
   output logic [15:0]      imm,
   output logic             rep,
   output logic [2:0]       sop_l,
   output logic             exec_st,
   output logic [LEN_W-1:0] inst_len
);

   typedef enum logic [2:0] {OPC, MRM, OFF0, OFF1, IMM0, IMM1, EXEC} state_t;

   state_t           state_q, state_d;
   logic [7:0]       opcode_q, opcode_d, modrm_q, modrm_d;
   logic [15:0]      off_q, off_d, imm_q, imm_d;
   logic             rep_q, rep_d, exec_st_q, exec_st_d;
   logic [2:0]       sop_l_q, sop_l_d;
   logic [LEN_W-1:0] inst_len_q, inst_len_d;
   logic             pop_req;

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      modrm_d    = modrm_q;
      off_d      = off_q;
      imm_d      = imm_q;
      rep_d      = rep_q;
      sop_l_d    = sop_l_q;
      inst_len_d = inst_len_q;
      pop_req    = 1'b0;
      unique case (state_q)
         OPC: begin
            pop_req = q_valid;
            if (q_valid) begin
               unique case (q_byte)
                  8'hF2, 8'hF3:                rep_d   = 1'b1;
                  8'h26, 8'h2E, 8'h36, 8'h3E:  sop_l_d = {1'b1, q_byte[4:3]};
                  8'hF0: ;
                  default: begin
                     opcode_d = q_byte;
                     modrm_d  = 8'h00;
                     off_d    = 16'h0000;
                     imm_d    = 16'h0000;
                     state_d  = MRM;
                  end
               endcase
            end
         end
         MRM: begin
            if (!need_modrm) state_d = OFF0;
            else begin
               pop_req = q_valid;
               if (q_valid) begin
                  modrm_d = q_byte;
                  state_d = OFF0;
               end
            end
         end
         OFF0: begin
            if (!need_off) state_d = IMM0;
            else begin
               pop_req = q_valid;
               if (q_valid) begin
                  off_d   = {{8{q_byte[7]}}, q_byte};
                  state_d = off_size ? OFF1 : IMM0;
               end
            end
         end
         OFF1: begin
            if (!need_off) state_d = IMM0;
            else begin
               pop_req = q_valid;
               if (q_valid) begin
                  off_d[15:8] = q_byte;
                  state_d     = IMM0;
               end
            end
         end
         IMM0: begin
            if (!need_imm) state_d = EXEC;
            else begin
               pop_req = q_valid;
               if (q_valid) begin
                  imm_d   = {{8{q_byte[7]}}, q_byte};
                  state_d = imm_size ? IMM1 : EXEC;
               end
            end
         end
         IMM1: begin
            if (!need_imm) state_d = EXEC;
            else begin
               pop_req = q_valid;
               if (q_valid) begin
                  imm_d[15:8] = q_byte;
                  state_d     = EXEC;
               end
            end
         end
         EXEC: begin
            if (end_seq) begin
               state_d    = OPC;
               rep_d      = 1'b0;
               sop_l_d    = 3'b000;
               inst_len_d = '0;
            end
         end
         default: state_d = OPC;
      endcase
      // reset and stall both suppress the pop so the queue never loses a byte
      q_pop = pop_req & ~block & rst;
      if (q_pop && inst_len_q != {LEN_W{1'b1}}) inst_len_d = inst_len_q + 1'b1;
      exec_st_d = (state_d == EXEC);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= OPC;
         opcode_q   <= 8'h00;
         modrm_q    <= 8'h00;
         off_q      <= 16'h0000;
         imm_q      <= 16'h0000;
         rep_q      <= 1'b0;
         sop_l_q    <= 3'b000;
         exec_st_q  <= 1'b0;
         inst_len_q <= '0;
      end else if (!block) begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         modrm_q    <= modrm_d;
         off_q      <= off_d;
         imm_q      <= imm_d;
         rep_q      <= rep_d;
         sop_l_q    <= sop_l_d;
         exec_st_q  <= exec_st_d;
         inst_len_q <= inst_len_d;
      end
   end

   assign opcode   = opcode_q;
   assign modrm    = modrm_q;
   assign off      = off_q;
   assign imm      = imm_q;
   assign rep      = rep_q;
   assign sop_l    = sop_l_q;
   assign exec_st  = exec_st_q;
   assign inst_len = inst_len_q;

endmodule

// File: tb/tb_zet_fetch_ctrl.sv
// Randomized bench for zet_fetch_ctrl: each instruction is parsed by a byte-list model
// and compared with the latched fields once exec_st rises.
module tb_zet_fetch_ctrl;
   logic        clk = 1'b0, rst = 1'b0;
   logic [7:0]  q_byte = 8'h00;
   logic        q_valid = 1'b0, q_pop, block = 1'b0;
   logic        need_modrm = 1'b0, need_off = 1'b0, need_imm = 1'b0;
   logic        off_size = 1'b0, imm_size = 1'b0, end_seq = 1'b0;
   logic [7:0]  opcode, modrm;
   logic [15:0] off, imm;
   logic        rep, exec_st;
   logic [2:0]  sop_l;
   logic [3:0]  inst_len;

   int errors = 0, checks = 0;
   logic [7:0] inst[$];
   logic [7:0] bq[$];
   logic [7:0] pre_tab[7] = '{8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0};

   zet_fetch_ctrl #(.LEN_W(4)) dut (
      .clk(clk), .rst(rst), .q_byte(q_byte), .q_valid(q_valid), .q_pop(q_pop),
      .block(block), .need_modrm(need_modrm), .need_off(need_off), .need_imm(need_imm),
      .off_size(off_size), .imm_size(imm_size), .end_seq(end_seq),
      .opcode(opcode), .modrm(modrm), .off(off), .imm(imm), .rep(rep),
      .sop_l(sop_l), .exec_st(exec_st), .inst_len(inst_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_pre(input logic [7:0] b);
      return b inside {8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0};
   endfunction

   // end the instruction; first cycle also proves end_seq is ignored under block
   task automatic fin_inst(input logic [7:0] op);
      @(negedge clk);
      q_valid = 1'b1; q_byte = 8'h90; block = 1'b1; end_seq = 1'b1;
      #1 chk("exec_nopop", q_pop, 0);
      @(posedge clk); #1 chk("blk_hold", exec_st, 1);
      @(negedge clk);
      block = 1'b0; q_valid = 1'b0;
      #1 chk("exec_nopop2", q_pop, 0);
      @(posedge clk); #1;
      chk("end_exec", exec_st, 0);
      chk("end_rep", rep, 0);
      chk("end_sop", sop_l, 0);
      chk("end_len", inst_len, 0);
      chk("end_opc", opcode, op);
      @(negedge clk) end_seq = 1'b0;
   endtask

   task automatic go(input bit rnd, input int gap_at, input bit fin);
      int i, cyc, npop, gap, lat;
      logic r;
      logic [2:0] s;
      logic [7:0] op, m;
      logic [15:0] o, im;
      i = 0; cyc = 0; npop = 0; gap = 3; r = 1'b0; s = 3'b000; m = 8'h00; o = 16'h0; im = 16'h0;
      while (is_pre(inst[i])) begin
         case (inst[i])
            8'hF2, 8'hF3: r = 1'b1;
            8'h26: s = 3'b100;
            8'h2E: s = 3'b101;
            8'h36: s = 3'b110;
            8'h3E: s = 3'b111;
            default: ;
         endcase
         i++;
      end
      op = inst[i]; i++;
      // one cycle per prefix/opcode, then one each for MRM/OFF0/IMM0, plus 16-bit second bytes
      lat = i + 3 + ((need_off && off_size) ? 1 : 0) + ((need_imm && imm_size) ? 1 : 0)
            + ((gap_at >= 0) ? 3 : 0);
      if (need_modrm) begin m = inst[i]; i++; end
      if (need_off) begin
         if (off_size) begin o = {inst[i+1], inst[i]}; i += 2; end
         else begin o = 16'($signed(inst[i])); i++; end
      end
      if (need_imm) begin
         if (imm_size) begin im = {inst[i+1], inst[i]}; i += 2; end
         else begin im = 16'($signed(inst[i])); i++; end
      end
      bq = inst;
      while (!exec_st && cyc < 300) begin
         @(negedge clk);
         block = rnd && ($urandom_range(0, 9) == 0);
         q_valid = (bq.size() > 0) && !(npop == gap_at && gap > 0) && (!rnd || $urandom_range(0, 4) != 0);
         if (npop == gap_at && gap > 0) begin
            gap--;
            if (gap == 0) chk("off_partial", off[7:0], inst[gap_at-1]);
         end
         q_byte = q_valid ? bq[0] : 8'($urandom);
         #1;
         chk("pop_gate", q_pop && !(q_valid && !block), 0);
         if (q_pop) begin
            void'(bq.pop_front());
            npop++;
         end
         @(posedge clk); #1 cyc++;
      end
      block = 1'b0;
      chk("exec_st", exec_st, 1);
      chk("bytes_left", bq.size(), 0);
      chk("opcode", opcode, op);
      chk("modrm", modrm, m);
      chk("off", off, o);
      chk("imm", imm, im);
      chk("rep", rep, r);
      chk("sop_l", sop_l, s);
      chk("inst_len", inst_len, (inst.size() > 15) ? 15 : inst.size());
      if (!rnd) chk("latency", cyc, lat);
      if (fin) fin_inst(op);
   endtask

   task automatic set_need(input logic m, input logic o, input logic i, input logic os, input logic is);
      need_modrm = m; need_off = o; need_imm = i; off_size = os; imm_size = is;
   endtask

   task automatic reset_chk(input string tag);
      @(negedge clk);
      rst = 1'b0; q_valid = 1'b1; q_byte = 8'h90;
      #1 chk({tag, "_pop"}, q_pop, 0);
      @(posedge clk); #1;
      chk({tag, "_outs"}, {opcode, modrm, rep, sop_l, exec_st, inst_len}, 0);
      chk({tag, "_offimm"}, {off, imm}, 0);
      @(negedge clk);
      rst = 1'b1; q_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] op;
      repeat (2) @(posedge clk);
      #1 chk("init_outs", {opcode, modrm, rep, sop_l, exec_st, inst_len, q_pop}, 0);
      chk("init_offimm", {off, imm}, 0);
      @(negedge clk) rst = 1'b1;

      set_need(0, 0, 0, 0, 0);
      inst = '{8'h90};                             go(0, -1, 1);
      inst = '{8'hF3, 8'h2E, 8'hA5};               go(0, -1, 1);
      set_need(1, 1, 0, 0, 0);
      inst = '{8'h8B, 8'h46, 8'hFE};               go(0, -1, 1);
      set_need(1, 1, 1, 1, 1);
      inst = '{8'hC7, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56}; go(0, -1, 1);
      inst = '{8'hC7, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56}; go(0, 3, 1);
      set_need(0, 1, 1, 0, 0);
      inst = '{8'h05, 8'h80, 8'h7F};               go(0, -1, 1);

      // more prefixes than the length counter can hold
      set_need(0, 0, 0, 0, 0);
      inst.delete();
      repeat (16) inst.push_back(8'hF0);
      inst.push_back(8'hF3); inst.push_back(8'h26); inst.push_back(8'h90);
      go(0, -1, 1);

      // abort in OFF1 with the high displacement byte missing
      set_need(1, 1, 1, 1, 1);
      bq = '{8'hC7, 8'h06, 8'h34};
      repeat (6) begin
         @(negedge clk);
         q_valid = bq.size() > 0;
         q_byte = q_valid ? bq[0] : 8'h00;
         #1 if (q_pop) void'(bq.pop_front());
      end
      chk("off1_lo", off, 16'h0034);
      reset_chk("rst_off1");
      set_need(0, 0, 0, 0, 0);
      inst = '{8'h90};                             go(0, -1, 1);

      // abort mid-EXEC
      inst = '{8'h3E, 8'hF2, 8'h40};               go(0, -1, 0);
      reset_chk("rst_exec");
      inst = '{8'h90};                             go(0, -1, 1);

      repeat (40) begin
         inst.delete();
         repeat ($urandom_range(0, 4)) inst.push_back(pre_tab[$urandom_range(0, 6)]);
         do op = 8'($urandom); while (is_pre(op));
         inst.push_back(op);
         set_need(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         repeat (int'(need_modrm) + (need_off ? 1 + int'(off_size) : 0) + (need_imm ? 1 + int'(imm_size) : 0))
            inst.push_back(8'($urandom));
         go(1, -1, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
